issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL: clock_i  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: validA_i/validB_i  in  1 each  decoded instruction present in slot A/B.
REQ-004 SHALL: pWriteA_i, pReadA_i, sReadA_i (and B)  in  1 each  register-access flags from decode.
REQ-005 SHALL: pRegA_i/pRegB_i  in  5  primary register address; sRegA_i/sRegB_i  in  5  secondary register address, meaningful only when sRead set.
REQ-006 SHALL: fTypeA_i/fTypeB_i  in  2  function type: 0 invalid, 1 arithmetic, 2 load/store, 3 flow control.
REQ-007 SHALL: wbA_i/wbB_i  in  1, wbAddrA_i/wbAddrB_i  in  5  writeback events from exec units A/B.
REQ-008 SHALL: issueA_o/issueB_o  out  1  registered issue strobes to register-read stage.
REQ-009 SHALL: hold_o  out  1  combinational; freezes PC, fetch, parse and decode registers while high.
REQ-010 SHALL: busy_o  out  32  scoreboard; bit n = register n has a pending write.
REQ-011 SHALL: holdCount_o  out  16  saturating count of cycles with hold_o high.

Function
REQ-012 SHALL: hazard(X) = valid && ((pRead|pWrite) && busy[pReg] || sRead && busy[sReg]); busy sampled from register, no same-cycle writeback bypass (1-cycle release latency).
REQ-013 SHALL: depBA = pWriteA && ((pReadB|pWriteB) && pRegB==pRegA || sReadB && sRegB==pRegA).
REQ-014 SHALL: an instruction with fType==3 is issued alone and only when busy_o==0; fType==0 with valid set is treated as not valid.
REQ-015 SHALL: FSM states RUN and SPLIT; in RUN, A blocked (hazard or flow-not-drained) -> no issue, hold_o=1, stay RUN.
REQ-016 SHALL: in RUN, A clear and B valid with hazard(B), depBA, or fType of A or B ==3 -> issue A only, hold_o=1, next SPLIT.
REQ-017 SHALL: in RUN, A clear and (B not valid or B clear of REQ-016 conditions) -> issue A and B as valid, hold_o=0.
REQ-018 SHALL: in RUN, A not valid and B valid -> B evaluated alone as in SPLIT.
REQ-019 SHALL: in SPLIT, only B evaluated; B clear -> issueB next cycle, hold_o=0, next RUN; else hold_o=1, stay SPLIT.
REQ-020 SHALL: issue strobes appear exactly one cycle after the deciding cycle; no instruction issued twice.
REQ-021 SHALL: on the issuing edge, busy[pReg] set for each issued instruction with pWrite.
REQ-022 SHALL: wbA_i/wbB_i clear busy[wbAddr] on same edge; set wins over clear for same address; wbA and wbB to same address clear once.
REQ-023 SHALL: holdCount_o increments each cycle hold_o=1, saturates at 16'hFFFF, never wraps.

Reset
REQ-024 SHALL: reset_i low asynchronously forces state RUN, busy_o=0, issueA_o=0, issueB_o=0, holdCount_o=0; hold_o=0 while in reset.
REQ-025 SHALL: reset mid-SPLIT discards the held B; no issue strobe in the first cycle after release.

Structure
REQ-026 SHALL: shared package pa_pkg holds function-type encodings, FSM state encoding, NUM_REGS=32, REG_AW=5.
REQ-027 SHALL: scoreboard (set/clear/busy vector) is a sub-module pa_scoreboard; FSM, hazard logic, counter in issue_scheduler.

Verification
REQ-028 SHALL: A=ADD pW r3, B=ADD pR r5, busy=0 -> issueA=issueB=1 next cycle, hold_o=0, busy[3]=1.
REQ-029 SHALL: A pW r3, B pR r3 -> cycle1 issueA only, hold=1; SPLIT holds until wbA_i r3, B issues the cycle after busy[3] clears.
REQ-030 SHALL: busy[7]=1, A sRead r7 -> hold_o=1, no issue, holdCount_o increments each cycle until writeback.
REQ-031 SHALL: A fType=3 with busy[2]=1 -> held until busy_o==0, then issued alone; B issued following cycle.
REQ-032 SHALL: same-edge issue pW r9 and wbB_i r9 -> busy[9]=1 after edge.
REQ-033 SHALL: reset_i low during SPLIT -> busy_o=0, state RUN, outputs 0; holdCount_o forced to 16'hFFFF stays saturated under further holds.

Source files
------------

// File: rtl/pa_pkg.sv
// pa_pkg -- shared definitions for the dual-slot issue stage.
//   NUM_REGS / REG_AW : architectural register file size and address width.
//   fnType_e          : decoded function type of an instruction slot.
//   schedState_e      : issue scheduler FSM encoding.
//   slot_t            : one decoded instruction slot as seen by the scheduler.
//   slotHazard()      : true when a live slot touches a register with a pending write.
package pa_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;

    typedef enum logic [1:0] {
        FnInvalid = 2'd0,
        FnArith   = 2'd1,
        FnLdSt    = 2'd2,
        FnFlow    = 2'd3
    } fnType_e;

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StSplit = 1'b1
    } schedState_e;

    typedef struct packed {
        logic              valid;   // present and not FnInvalid
        logic              pWrite;
        logic              pRead;
        logic              sRead;
        logic [REG_AW-1:0] pReg;
        logic [REG_AW-1:0] sReg;
        fnType_e           fType;
    } slot_t;

    function automatic logic slotHazard(input slot_t s, input logic [NUM_REGS-1:0] busy);
        return s.valid && (((s.pRead || s.pWrite) && busy[s.pReg]) || (s.sRead && busy[s.sReg]));
    endfunction

endpackage

// File: rtl/pa_scoreboard.sv
// pa_scoreboard -- pending-write scoreboard, one busy bit per register.
//   clock_i, reset_i          : clock, asynchronous active-low reset
//   setA_i/setB_i + addresses : mark a register busy (issued instruction writes it)
//   clrA_i/clrB_i + addresses : writeback releases a register
//   busy_o                    : registered busy vector
// A set and a clear of the same register on one edge leaves it busy.
module pa_scoreboard
    import pa_pkg::*;
(
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                setA_i,
    input  logic [REG_AW-1:0]   setAddrA_i,
    input  logic                setB_i,
    input  logic [REG_AW-1:0]   setAddrB_i,
    input  logic                clrA_i,
    input  logic [REG_AW-1:0]   clrAddrA_i,
    input  logic                clrB_i,
    input  logic [REG_AW-1:0]   clrAddrB_i,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busyD, busyQ;

    // Clears first, sets last, so a new pending write always survives a writeback.
    always_comb begin
        busyD = busyQ;
        if (clrA_i) busyD[clrAddrA_i] = 1'b0;
        if (clrB_i) busyD[clrAddrB_i] = 1'b0;
        if (setA_i) busyD[setAddrA_i] = 1'b1;
        if (setB_i) busyD[setAddrB_i] = 1'b1;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            busyQ <= '0;
        end else begin
            busyQ <= busyD;
        end
    end

    assign busy_o = busyQ;

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler -- in-order dual-issue scheduler for decode slots A (older) and B.
//   clock_i, reset_i            : clock, asynchronous active-low reset
//   validX_i, pWriteX_i, ...    : decoded slot X (register flags, addresses, function type)
//   wbX_i, wbAddrX_i            : writeback from exec unit X, releases a busy register
//   issueA_o, issueB_o          : registered issue strobes to register read
//   hold_o                      : combinational front-end freeze
//   busy_o                      : scoreboard, bit n = register n has a pending write
//   holdCount_o                 : saturating count of held cycles
// When A may go but B may not go with it, A issues alone and the FSM parks in StSplit
// evaluating only B until it can issue.
module issue_scheduler
    import pa_pkg::*;
(
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                validA_i,
    input  logic                pWriteA_i,
    input  logic                pReadA_i,
    input  logic                sReadA_i,
    input  logic [REG_AW-1:0]   pRegA_i,
    input  logic [REG_AW-1:0]   sRegA_i,
    input  logic [1:0]          fTypeA_i,
    input  logic                validB_i,
    input  logic                pWriteB_i,
    input  logic                pReadB_i,
    input  logic                sReadB_i,
    input  logic [REG_AW-1:0]   pRegB_i,
    input  logic [REG_AW-1:0]   sRegB_i,
    input  logic [1:0]          fTypeB_i,
    input  logic                wbA_i,
    input  logic [REG_AW-1:0]   wbAddrA_i,
    input  logic                wbB_i,
    input  logic [REG_AW-1:0]   wbAddrB_i,
    output logic                issueA_o,
    output logic                issueB_o,
    output logic                hold_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [15:0]         holdCount_o
);

    slot_t               slotA, slotB;
    logic [NUM_REGS-1:0] busy;
    logic                anyBusy, readyA, readyB, depBA, pairConflict;
    logic                holdRaw, issueAD, issueBD, issueAQ, issueBQ;
    schedState_e         stateD, stateQ;
    logic [15:0]         holdCountQ;

    always_comb begin
        slotA        = '0;
        slotA.valid  = validA_i && (fTypeA_i != FnInvalid);
        slotA.pWrite = pWriteA_i;
        slotA.pRead  = pReadA_i;
        slotA.sRead  = sReadA_i;
        slotA.pReg   = pRegA_i;
        slotA.sReg   = sRegA_i;
        slotA.fType  = fnType_e'(fTypeA_i);
        slotB        = '0;
        slotB.valid  = validB_i && (fTypeB_i != FnInvalid);
        slotB.pWrite = pWriteB_i;
        slotB.pRead  = pReadB_i;
        slotB.sRead  = sReadB_i;
        slotB.pReg   = pRegB_i;
        slotB.sReg   = sRegB_i;
        slotB.fType  = fnType_e'(fTypeB_i);
    end

    // Busy is the registered vector: a writeback frees its register one cycle later.
    assign anyBusy = |busy;
    assign readyA  = !slotHazard(slotA, busy) && !((slotA.fType == FnFlow) && anyBusy);
    assign readyB  = !slotHazard(slotB, busy) && !((slotB.fType == FnFlow) && anyBusy);

    // B consumes or overwrites the register A is about to write.
    assign depBA = slotA.pWrite &&
                   ((((slotB.pRead || slotB.pWrite) && (slotB.pReg == slotA.pReg))) ||
                    (slotB.sRead && (slotB.sReg == slotA.pReg)));

    assign pairConflict = slotB.valid && (slotHazard(slotB, busy) || depBA ||
                          (slotA.fType == FnFlow) || (slotB.fType == FnFlow));

    always_comb begin
        stateD  = stateQ;
        issueAD = 1'b0;
        issueBD = 1'b0;
        holdRaw = 1'b0;
        case (stateQ)
            StRun: begin
                if (slotA.valid) begin
                    if (!readyA) begin
                        holdRaw = 1'b1;
                    end else if (pairConflict) begin
                        issueAD = 1'b1;
                        holdRaw = 1'b1;
                        stateD  = StSplit;
                    end else begin
                        issueAD = 1'b1;
                        issueBD = slotB.valid;
                    end
                end else if (slotB.valid) begin
                    if (readyB) issueBD = 1'b1;
                    else        holdRaw = 1'b1;
                end
            end
            StSplit: begin
                // A already left; the frozen A slot is ignored here.
                if (slotB.valid && !readyB) begin
                    holdRaw = 1'b1;
                end else begin
                    issueBD = slotB.valid;
                    stateD  = StRun;
                end
            end
            default: stateD = StRun;
        endcase
    end

    assign hold_o = holdRaw && reset_i;

    pa_scoreboard u_scoreboard (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .setA_i     (issueAD && slotA.pWrite),
        .setAddrA_i (slotA.pReg),
        .setB_i     (issueBD && slotB.pWrite),
        .setAddrB_i (slotB.pReg),
        .clrA_i     (wbA_i),
        .clrAddrA_i (wbAddrA_i),
        .clrB_i     (wbB_i),
        .clrAddrB_i (wbAddrB_i),
        .busy_o     (busy)
    );

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            stateQ     <= StRun;
            issueAQ    <= 1'b0;
            issueBQ    <= 1'b0;
            holdCountQ <= '0;
        end else begin
            stateQ  <= stateD;
            issueAQ <= issueAD;
            issueBQ <= issueBD;
            if (hold_o && (holdCountQ != 16'hFFFF)) begin
                holdCountQ <= holdCountQ + 16'd1;
            end
        end
    end

    assign issueA_o    = issueAQ;
    assign issueB_o    = issueBQ;
    assign busy_o      = busy;
    assign holdCount_o = holdCountQ;

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler -- directed stimulus, per-cycle comparison against a slot-level model,
// plus hand-computed literal checks at key points of each scenario.
module tb_issue_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid  [2];
    logic        pW     [2];
    logic        pR     [2];
    logic        sR     [2];
    logic [4:0]  pReg   [2];
    logic [4:0]  sReg   [2];
    logic [1:0]  ft     [2];
    logic        wb     [2];
    logic [4:0]  wbAddr [2];
    logic        issueA, issueB, hold;
    logic [31:0] busy;
    logic [15:0] holdCount;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    issue_scheduler dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .validA_i    (valid[0]),
        .pWriteA_i   (pW[0]),
        .pReadA_i    (pR[0]),
        .sReadA_i    (sR[0]),
        .pRegA_i     (pReg[0]),
        .sRegA_i     (sReg[0]),
        .fTypeA_i    (ft[0]),
        .validB_i    (valid[1]),
        .pWriteB_i   (pW[1]),
        .pReadB_i    (pR[1]),
        .sReadB_i    (sR[1]),
        .pRegB_i     (pReg[1]),
        .sRegB_i     (sReg[1]),
        .fTypeB_i    (ft[1]),
        .wbA_i       (wb[0]),
        .wbAddrA_i   (wbAddr[0]),
        .wbB_i       (wb[1]),
        .wbAddrB_i   (wbAddr[1]),
        .issueA_o    (issueA),
        .issueB_o    (issueB),
        .hold_o      (hold),
        .busy_o      (busy),
        .holdCount_o (holdCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: pending registers as a plain array ----------------
    bit mBusy [32];
    bit mSplit   = 1'b0;
    int mHold    = 0;
    bit eIssueA  = 1'b0;
    bit eIssueB  = 1'b0;

    function automatic bit live(input int i);
        return valid[i] && (ft[i] != 2'd0);
    endfunction

    function automatic bit touchesBusy(input int i);
        return ((pR[i] || pW[i]) && mBusy[pReg[i]]) || (sR[i] && mBusy[sReg[i]]);
    endfunction

    function automatic bit anyPending();
        bit any = 1'b0;
        for (int r = 0; r < 32; r++) any = any | mBusy[r];
        return any;
    endfunction

    function automatic bit mustWait(input int i);
        return touchesBusy(i) || ((ft[i] == 2'd3) && anyPending());
    endfunction

    function automatic bit bNeedsA();
        return pW[0] && (((pR[1] || pW[1]) && (pReg[1] == pReg[0])) ||
                         (sR[1] && (sReg[1] == pReg[0])));
    endfunction

    function automatic logic [31:0] busyWord();
        logic [31:0] w;
        for (int r = 0; r < 32; r++) w[r] = mBusy[r];
        return w;
    endfunction

    initial begin : compare
        bit goA, goB, hExp, toSplit, setIt, clrIt;
        for (int r = 0; r < 32; r++) mBusy[r] = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                check("rst_hold", 32'(hold), 32'd0);
                check("rst_issueA", 32'(issueA), 32'd0);
                check("rst_issueB", 32'(issueB), 32'd0);
                check("rst_busy", busy, 32'd0);
                check("rst_holdCount", 32'(holdCount), 32'd0);
                for (int r = 0; r < 32; r++) mBusy[r] = 1'b0;
                mSplit = 1'b0; mHold = 0; eIssueA = 1'b0; eIssueB = 1'b0;
            end else begin
                goA = 1'b0; goB = 1'b0; hExp = 1'b0; toSplit = mSplit;
                if (mSplit) begin
                    if (live(1) && mustWait(1)) hExp = 1'b1;
                    else begin goB = live(1); toSplit = 1'b0; end
                end else if (live(0)) begin
                    if (mustWait(0)) begin
                        hExp = 1'b1;
                    end else if (live(1) && (touchesBusy(1) || bNeedsA() ||
                                             ft[0] == 2'd3 || ft[1] == 2'd3)) begin
                        goA = 1'b1; hExp = 1'b1; toSplit = 1'b1;
                    end else begin
                        goA = 1'b1; goB = live(1);
                    end
                end else if (live(1)) begin
                    if (mustWait(1)) hExp = 1'b1;
                    else goB = 1'b1;
                end
                check("model_hold", 32'(hold), 32'(hExp));
                check("model_issueA", 32'(issueA), 32'(eIssueA));
                check("model_issueB", 32'(issueB), 32'(eIssueB));
                check("model_busy", busy, busyWord());
                check("model_holdCount", 32'(holdCount), 32'(mHold));
                for (int r = 0; r < 32; r++) begin
                    setIt = (goA && pW[0] && int'(pReg[0]) == r) ||
                            (goB && pW[1] && int'(pReg[1]) == r);
                    clrIt = (wb[0] && int'(wbAddr[0]) == r) || (wb[1] && int'(wbAddr[1]) == r);
                    if (setIt) mBusy[r] = 1'b1;
                    else if (clrIt) mBusy[r] = 1'b0;
                end
                if (hExp && mHold < 65535) mHold++;
                eIssueA = goA; eIssueB = goB; mSplit = toSplit;
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setSlot(input int i, input logic [1:0] f, input logic w, input logic r,
                           input logic s, input logic [4:0] pr, input logic [4:0] sr);
        valid[i] = 1'b1; ft[i] = f; pW[i] = w; pR[i] = r; sR[i] = s; pReg[i] = pr; sReg[i] = sr;
    endtask

    task automatic clearSlots();
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; ft[i] = 2'd0; pW[i] = 1'b0; pR[i] = 1'b0; sR[i] = 1'b0;
            pReg[i] = 5'd0; sReg[i] = 5'd0;
        end
    endtask

    task automatic wbOff();
        for (int i = 0; i < 2; i++) begin
            wb[i] = 1'b0; wbAddr[i] = 5'd0;
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin : stimulus
        clearSlots();
        wbOff();
        tick();
        tick();
        check("reset_busy", busy, 32'd0);
        check("reset_holdCount", 32'(holdCount), 32'd0);
        check("reset_hold", 32'(hold), 32'd0);
        reset = 1'b1;

        // Independent pair: both issue, r3 becomes busy.
        setSlot(0, 2'd1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0);
        setSlot(1, 2'd1, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0);
        #1 check("pair_hold", 32'(hold), 32'd0);
        tick();
        check("pair_issueA", 32'(issueA), 32'd1);
        check("pair_issueB", 32'(issueB), 32'd1);
        check("pair_busy", busy, 32'h0000_0008);
        clearSlots();
        tick();
        wb[0] = 1'b1; wbAddr[0] = 5'd3;
        tick();
        wbOff();
        check("pair_wb_busy", busy, 32'd0);

        // B reads what A writes: split, B waits for the writeback.
        doReset();
        setSlot(0, 2'd1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0);
        setSlot(1, 2'd1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd0);
        #1 check("raw_hold0", 32'(hold), 32'd1);
        tick();
        check("raw_issueA", 32'(issueA), 32'd1);
        check("raw_issueB", 32'(issueB), 32'd0);
        check("raw_hold1", 32'(hold), 32'd1);
        tick();
        check("raw_wait_issueB", 32'(issueB), 32'd0);
        wb[0] = 1'b1; wbAddr[0] = 5'd3;
        tick();
        wbOff();
        check("raw_busy_clear", busy, 32'd0);
        check("raw_hold_release", 32'(hold), 32'd0);
        check("raw_still_no_B", 32'(issueB), 32'd0);
        tick();
        check("raw_issueB_late", 32'(issueB), 32'd1);
        check("raw_noA_again", 32'(issueA), 32'd0);
        clearSlots();
        tick();

        // Secondary read of a busy register holds and counts.
        doReset();
        setSlot(0, 2'd2, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0);
        tick();
        check("sr_busy7", busy, 32'h0000_0080);
        setSlot(0, 2'd1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd7);
        #1 check("sr_hold", 32'(hold), 32'd1);
        tick();
        check("sr_count1", 32'(holdCount), 32'd1);
        check("sr_noissue", 32'(issueA), 32'd0);
        tick();
        check("sr_count2", 32'(holdCount), 32'd2);
        wb[1] = 1'b1; wbAddr[1] = 5'd7;
        tick();
        wbOff();
        check("sr_count3", 32'(holdCount), 32'd3);
        #1 check("sr_released", 32'(hold), 32'd0);
        tick();
        check("sr_issueA", 32'(issueA), 32'd1);
        check("sr_count_final", 32'(holdCount), 32'd3);
        clearSlots();

        // Flow control waits for an empty scoreboard, then goes alone.
        doReset();
        setSlot(0, 2'd1, 1'b1, 1'b0, 1'b0, 5'd2, 5'd0);
        tick();
        setSlot(0, 2'd3, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        setSlot(1, 2'd1, 1'b0, 1'b1, 1'b0, 5'd6, 5'd0);
        #1 check("flow_hold", 32'(hold), 32'd1);
        tick();
        check("flow_noissue", 32'(issueA), 32'd0);
        wb[0] = 1'b1; wbAddr[0] = 5'd2;
        tick();
        wbOff();
        check("flow_drained_hold", 32'(hold), 32'd1);
        tick();
        check("flow_issueA", 32'(issueA), 32'd1);
        check("flow_alone", 32'(issueB), 32'd0);
        tick();
        check("flow_then_B", 32'(issueB), 32'd1);
        clearSlots();

        // Set wins over same-edge writeback; dual writeback to one address.
        setSlot(0, 2'd1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd0);
        wb[1] = 1'b1; wbAddr[1] = 5'd9;
        tick();
        clearSlots();
        check("setwins_busy9", busy, 32'h0000_0200);
        wb[0] = 1'b1; wbAddr[0] = 5'd9;
        tick();
        wbOff();
        check("dualwb_busy", busy, 32'd0);

        // Invalid-typed A: B issues alone. Invalid-typed B: A issues without hold.
        setSlot(0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd4, 5'd0);
        setSlot(1, 2'd1, 1'b1, 1'b0, 1'b0, 5'd4, 5'd0);
        tick();
        check("bonly_issueA", 32'(issueA), 32'd0);
        check("bonly_issueB", 32'(issueB), 32'd1);
        check("bonly_busy", busy, 32'h0000_0010);
        setSlot(0, 2'd2, 1'b0, 1'b1, 1'b0, 5'd1, 5'd0);
        setSlot(1, 2'd0, 1'b1, 1'b1, 1'b0, 5'd4, 5'd0);
        wb[0] = 1'b1; wbAddr[0] = 5'd4;
        #1 check("aonly_hold", 32'(hold), 32'd0);
        tick();
        wbOff();
        clearSlots();
        check("aonly_issueA", 32'(issueA), 32'd1);
        check("aonly_issueB", 32'(issueB), 32'd0);

        // Saturate the hold counter, then reset while B is parked.
        doReset();
        setSlot(0, 2'd1, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0);
        tick();
        setSlot(0, 2'd1, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0);
        for (int n = 0; n < 65540; n++) tick();
        check("sat_count", 32'(holdCount), 32'h0000_FFFF);
        wb[0] = 1'b1; wbAddr[0] = 5'd7;
        tick();
        wbOff();
        #1 check("sat_release", 32'(hold), 32'd0);
        tick();
        check("sat_issueA", 32'(issueA), 32'd1);
        setSlot(0, 2'd1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0);
        setSlot(1, 2'd1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd0);
        tick();
        check("sat_split_issueA", 32'(issueA), 32'd1);
        check("sat_split_hold", 32'(hold), 32'd1);
        check("sat_stays", 32'(holdCount), 32'h0000_FFFF);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", busy, 32'd0);
        check("midrst_issueA", 32'(issueA), 32'd0);
        check("midrst_hold", 32'(hold), 32'd0);
        check("midrst_count", 32'(holdCount), 32'd0);
        clearSlots();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_issueB", 32'(issueB), 32'd0);
        check("post_rst_issueA", 32'(issueA), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
